// File: rtl/dense_layer_seq_if.sv
// Bias/weight parameter stream feeding dense_layer_seq: one signed beat per
// transfer, accepted when p_valid and p_ready are both high.
interface dense_layer_seq_if #(
    parameter int DW = 8
);
    logic                 p_valid;
    logic signed [DW-1:0] p_data;
    logic                 p_ready;

    modport master (output p_valid, output p_data, input p_ready);
    modport slave  (input p_valid, input p_data, output p_ready);
endinterface

// File: rtl/dense_layer_seq.sv
// Fully-connected layer sequencer: one MAC evaluates N_OUT neurons in turn over a latched activation vector.
// Optional DENSE_RELU_EN clamps negative saturated results to zero before they are stored.
module dense_layer_seq #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_IN*DW-1:0]    in_vec,
    dense_layer_seq_if.slave      p_if,
    output logic [N_OUT*DW-1:0]   out_vec,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, BIAS, MAC, STORE, FIN} state_t;

    localparam int K_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DW - 1)));

    state_t                    state;
    logic [N_IN*DW-1:0]        x_reg;
    logic [K_W-1:0]            k;
    logic [J_W-1:0]            j;
    logic signed [ACC_W-1:0]   acc;

    logic signed [DW-1:0]      x_k;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DW-1:0]      sat_val;
    logic signed [DW-1:0]      store_val;
    logic                      beat;

    // Datapath: product of the current activation and beat, plus the shifted/saturated neuron result.
    always_comb begin
        beat    = p_if.p_valid && p_if.p_ready;
        x_k     = x_reg[k*DW +: DW];
        prod    = x_k * p_if.p_data;
        shifted = acc >>> SHIFT;
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[DW-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[DW-1:0];
        end else begin
            sat_val = shifted[DW-1:0];
        end
`ifdef DENSE_RELU_EN
        store_val = sat_val[DW-1] ? '0 : sat_val;
`else
        store_val = sat_val;
`endif
    end

    // Handshake outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_reg        <= '0;
            k            <= '0;
            j            <= '0;
            acc          <= '0;
            out_vec      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            p_if.p_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg        <= in_vec;
                        j            <= '0;
                        state        <= BIAS;
                        busy         <= 1'b1;
                        p_if.p_ready <= 1'b1;
                    end
                end
                BIAS: begin
                    if (beat) begin
                        acc   <= ACC_W'(p_if.p_data) <<< SHIFT;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (beat) begin
                        acc <= acc + ACC_W'(prod);
                        if (k == K_LAST) begin
                            state        <= STORE;
                            p_if.p_ready <= 1'b0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                STORE: begin
                    out_vec[j*DW +: DW] <= store_val;
                    if (j == J_LAST) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        j            <= j + 1'b1;
                        state        <= BIAS;
                        p_if.p_ready <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: two instances (SHIFT=0 and SHIFT=2) with N_IN=4, N_OUT=2.
// Expected results are hand-computed; ReLU expectations follow DENSE_RELU_EN.
module tb_dense_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
`ifdef DENSE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic [N_IN*DW-1:0]  in_vec_a, in_vec_b;
    logic [N_OUT*DW-1:0] out_a, out_b;
    logic busy_a, busy_b, done_a, done_b;

    dense_layer_seq_if #(.DW(DW)) pa ();
    dense_layer_seq_if #(.DW(DW)) pb ();

    always #5 clk = ~clk;

    dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_a), .in_vec(in_vec_a), .p_if(pa),
        .out_vec(out_a), .busy(busy_a), .done(done_a)
    );

    dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_b), .in_vec(in_vec_b), .p_if(pb),
        .out_vec(out_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] beats [10];
    int done_cyc, busy_cnt, done_seen;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] relu8(input logic [7:0] v);
        return (RELU && v[7]) ? 8'h00 : v;
    endfunction

    task automatic setBeats(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] b8,
                            input logic [7:0] b9);
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3; beats[4] = b4;
        beats[5] = b5; beats[6] = b6; beats[7] = b7; beats[8] = b8; beats[9] = b9;
    endtask

    // Runs one layer pass on instance sel; cycle 1 is the cycle after start is accepted.
    // poke_cyc re-pulses start with another vector mid-pass, abort_cyc raises rst and returns.
    task automatic applyStimulus(input int sel, input logic [31:0] x, input bit toggle,
                                 input int poke_cyc, input int abort_cyc,
                                 output int d_cyc, output int b_cnt);
        int idx, cyc;
        bit v, prev_v, prev_r;
        idx = 0; cyc = 0; d_cyc = 0; b_cnt = 0; prev_v = 1'b0; prev_r = 1'b0;
        if (sel == 0) begin
            in_vec_a = x; start_a = 1'b1;
        end else begin
            in_vec_b = x; start_b = 1'b1;
        end
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (prev_v && prev_r) idx++;
            if (cyc == poke_cyc) begin
                if (sel == 0) begin
                    in_vec_a = 32'h6464_6464; start_a = 1'b1;
                end else begin
                    in_vec_b = 32'h6464_6464; start_b = 1'b1;
                end
            end
            if ((sel == 0) ? busy_a : busy_b) b_cnt++;
            if ((sel == 0) ? done_a : done_b) begin
                d_cyc = cyc;
                break;
            end
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                break;
            end
            prev_r = (sel == 0) ? pa.p_ready : pb.p_ready;
            v      = (idx < 10) && (!toggle || (cyc % 2 == 1));
            prev_v = v;
            if (sel == 0) begin
                pa.p_valid = v; pa.p_data = v ? beats[idx] : 8'h55;
            end else begin
                pb.p_valid = v; pb.p_data = v ? beats[idx] : 8'h55;
            end
        end
        pa.p_valid = 1'b0;
        pb.p_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        in_vec_a = '0; in_vec_b = '0;
        pa.p_valid = 1'b0; pa.p_data = '0;
        pb.p_valid = 1'b0; pb.p_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_vec", {16'h0, out_a}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy_a}, 32'h0);
        checkOutput("rst_done", {31'h0, done_a}, 32'h0);
        checkOutput("rst_p_ready", {31'h0, pa.p_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic pass");
        setBeats(8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'hEC, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, -1, done_cyc, busy_cnt);
        checkOutput("basic_n0", {24'h0, out_a[7:0]}, 32'h0F);
        checkOutput("basic_n1", {24'h0, out_a[15:8]}, {24'h0, relu8(8'hE2)});
        checkOutput("basic_done_cyc", done_cyc, 13);
        checkOutput("basic_busy_cnt", busy_cnt, 12);

        $display("[TB] start around FIN");
        start_a = 1'b1;
        @(posedge clk); #1;
        checkOutput("fin_start_ignored", {31'h0, busy_a}, 32'h0);
        @(posedge clk); #1;
        checkOutput("idle_start_taken", {31'h0, busy_a}, 32'h1);
        start_a = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] saturation");
        setBeats(8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80);
        applyStimulus(0, 32'h7F7F_7F7F, 1'b0, -1, -1, done_cyc, busy_cnt);
        checkOutput("sat_hi", {24'h0, out_a[7:0]}, 32'h7F);
        checkOutput("sat_lo", {24'h0, out_a[15:8]}, {24'h0, relu8(8'h80)});
        checkOutput("sat_done_cyc", done_cyc, 13);
        @(posedge clk); #1;

        $display("[TB] backpressure");
        setBeats(8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'hEC, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, -1, -1, done_cyc, busy_cnt);
        checkOutput("bp_n0", {24'h0, out_a[7:0]}, 32'h0F);
        checkOutput("bp_n1", {24'h0, out_a[15:8]}, {24'h0, relu8(8'hE2)});
        checkOutput("bp_done_cyc", done_cyc, 13 + 8);
        checkOutput("bp_busy_cnt", busy_cnt, 20);
        @(posedge clk); #1;

        $display("[TB] start while busy");
        applyStimulus(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 3, -1, done_cyc, busy_cnt);
        checkOutput("poke_n0", {24'h0, out_a[7:0]}, 32'h0F);
        checkOutput("poke_n1", {24'h0, out_a[15:8]}, {24'h0, relu8(8'hE2)});
        checkOutput("poke_done_cyc", done_cyc, 13);
        @(posedge clk); #1;

        $display("[TB] shift positive");
        setBeats(8'd1, 8'd3, 8'd3, 8'd3, 8'd3, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(1, 32'h0101_0101, 1'b0, -1, -1, done_cyc, busy_cnt);
        checkOutput("shift_16", {24'h0, out_b[7:0]}, 32'h04);
        checkOutput("shift_m4", {24'h0, out_b[15:8]}, {24'h0, relu8(8'hFF)});
        checkOutput("shift_done_cyc", done_cyc, 13);
        @(posedge clk); #1;

        $display("[TB] shift floor and saturate");
        setBeats(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        applyStimulus(1, 32'h0101_0101, 1'b0, -1, -1, done_cyc, busy_cnt);
        checkOutput("shift_m5", {24'h0, out_b[7:0]}, {24'h0, relu8(8'hFE)});
        checkOutput("shift_sat", {24'h0, out_b[15:8]}, 32'h7F);
        @(posedge clk); #1;

        $display("[TB] reset mid-pass");
        setBeats(8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'hEC, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 9, done_cyc, busy_cnt);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_out_vec", {16'h0, out_a}, 32'h0);
        checkOutput("abort_busy", {31'h0, busy_a}, 32'h0);
        checkOutput("abort_p_ready", {31'h0, pa.p_ready}, 32'h0);
        done_seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_a) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        applyStimulus(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, -1, done_cyc, busy_cnt);
        checkOutput("rerun_n0", {24'h0, out_a[7:0]}, 32'h0F);
        checkOutput("rerun_n1", {24'h0, out_a[15:8]}, {24'h0, relu8(8'hE2)});
        checkOutput("rerun_done_cyc", done_cyc, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq.md
# dense_layer_seq

Parametrised fully-connected layer sequencer: evaluates N_OUT neurons one at a time over a latched N_IN-element activation vector using a single multiply-accumulate datapath. Bias and weights arrive as a valid/ready stream. Results are shifted, saturated and packed into an output vector. It sits between two layer stages of the classifier pipeline: it consumes the previous layer's packed register and produces the next layer's packed register.

## Interface
Parameters:
- N_IN, 32, number of input activations per neuron
- N_OUT, 10, number of neurons (output elements)
- DW, 8, signed width of activations, weights, bias and outputs
- ACC_W, 24, signed accumulator width; must be ≥ 2*DW + clog2(N_IN+1) + SHIFT
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a layer pass when the block is idle
- in_vec  in  N_IN*DW  packed signed activations; element i is [i*DW +: DW]
- p_valid  in  1  parameter beat valid
- p_data  in  DW  signed parameter beat (bias or weight)
- p_ready  out  1  block accepts a beat this cycle
- out_vec  out  N_OUT*DW  packed signed results; neuron j is [j*DW +: DW]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when all neurons are written

## Operation
- States: IDLE, BIAS, MAC, STORE, FIN.
- IDLE: when start=1, latch in_vec into an internal register, clear the neuron index and go to BIAS. start is ignored in every other state. in_vec may change after it is latched.
- BIAS: p_ready=1. On p_valid, acc ← sign-extended p_data <<< SHIFT, clear the input index, and go to MAC.
- MAC: p_ready=1. On each p_valid, acc ← acc + x[k]*p_data (signed, full-precision product) and k increments. On beat k=N_IN-1, go to STORE.
- STORE: p_ready=0. r = acc >>> SHIFT (floor). Saturate r to [-2^(DW-1), 2^(DW-1)-1]. Write the result into slice j of out_vec; other slices hold.
  - If j=N_OUT-1, go to FIN.
  - Otherwise, j increments and the next state is BIAS.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Stream order per neuron: bias, then w[0]..w[N_IN-1]. Neurons arrive in index order.
- A beat transfers only when p_valid and p_ready are both high. Gaps with p_valid=0 stall the FSM with no state change.
- out_vec holds its last values until overwritten by the next pass. It is not cleared at start.

## Timing
- Reset values: p_ready=0, busy=0, done=0, out_vec=0. State is IDLE and the indices are 0.
- A reset asserted in any state aborts the pass on the next edge with the values above. Partially written out_vec is zeroed.
- With start accepted at edge 0 and p_valid held high:
  - BIAS occupies cycle 1, MAC cycles 2..N_IN+1, and STORE cycle N_IN+2.
  - Each neuron takes N_IN+2 cycles.
  - done is high in cycle N_OUT*(N_IN+2)+1.
- Each stall cycle adds exactly one cycle of latency.
- Slice j is visible on out_vec from the cycle after its STORE.
- busy is high in BIAS, MAC and STORE.
- start coincident with FIN is ignored. start in the IDLE cycle after FIN is accepted.

## Configuration
- DENSE_RELU_EN defined: in STORE, a negative saturated result is written as 0 (ReLU after saturation).
- DENSE_RELU_EN undefined: the signed saturated value is written unchanged.
- Applies to all neurons. There is no runtime control.

## Test plan
Bench configuration: N_IN=4, N_OUT=2, DW=8, SHIFT=0 unless stated.
- Basic pass: x=[1,2,3,4]; neuron0 stream 5,1,1,1,1; neuron1 stream -20,-1,-1,-1,-1; p_valid constant. Required: out_vec[7:0]=15, out_vec[15:8]=-30 (0 with DENSE_RELU_EN), done in cycle 13, busy high in cycles 1–12.
- Saturation: x all 127, neuron0 stream 0,127,127,127,127 → 127. Neuron1 stream 0,-128×4 → -128.
- Shift: SHIFT=2, x=[1,1,1,1], stream 1,3,3,3,3. Accumulator = 4+12 = 16 → 4. Negative case: bias 0, weights -1×4 → acc -4 → -1; -5 floors to -2.
- Backpressure: basic pass with p_valid toggling 1,0,1,0… Required: identical results, done delayed by exactly the count of stall cycles, no beat accepted while p_ready=0.
- Reset mid-pass: assert rst during neuron1 MAC. Required: out_vec=0, busy=0, done never pulses. A fresh start then completes correctly.
- start while busy: pulse start during neuron0 MAC with a different in_vec. Required: ignored, results use the first latched vector.
